// File: rtl/delay_arbiter_pkg.sv
// Shared types for delay_arbiter: FSM state encoding and the fixed timer mode.
package delay_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic TIMER_MODE_COUNT_DOWN = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping past N_REQ-1.
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req_i,
    input  logic [$clog2(N_REQ)-1:0] ptr_i,
    output logic                     valid_o,
    output logic [$clog2(N_REQ)-1:0] idx_o
);

    localparam int IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0] at_or_after;
    logic [N_REQ-1:0] masked_req;
    logic [IDX_W-1:0] masked_idx;
    logic [IDX_W-1:0] plain_idx;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_mask
        assign at_or_after[gi] = (IDX_W'(gi) >= ptr_i);
    end

    assign masked_req = req_i & at_or_after;

    // Requests at/after the pointer win; otherwise wrap to the lowest set request.
    always_comb begin
        masked_idx = '0;
        plain_idx  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (masked_req[k]) begin
                masked_idx = IDX_W'(k);
            end
            if (req_i[k]) begin
                plain_idx = IDX_W'(k);
            end
        end
    end

    assign valid_o = |req_i;
    assign idx_o   = (|masked_req) ? masked_idx : plain_idx;

endmodule

// File: rtl/delay_arbiter.sv
// Round-robin sharing of one count-down timer among N_REQ delay requesters.
// Optional DELAY_ARBITER_ABORT_EN adds abort_i/aborted_o to cut a granted delay short.
module delay_arbiter
    import delay_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int CNT_W = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_i,
    input  logic [N_REQ*CNT_W-1:0]     delay_value_i,
`ifdef DELAY_ARBITER_ABORT_EN
    input  logic [N_REQ-1:0]           abort_i,
    output logic                       aborted_o,
`endif
    output logic [N_REQ-1:0]           done_o,
    output logic                       busy_o,
    output logic [$clog2(N_REQ)-1:0]   grant_idx_o,
    output logic                       timer_rst_o,
    output logic                       timer_enable_o,
    output logic                       timer_mode_o,
    output logic [CNT_W-1:0]           timer_count_down_value_o,
    input  logic                       timer_delay_pending_i
);

    localparam int IDX_W = $clog2(N_REQ);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] count_value_q, count_value_d;
    logic             abort_hit;

    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] ptr_after;
    logic [CNT_W-1:0] delay_slice [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
        assign delay_slice[gi] = delay_value_i[gi*CNT_W +: CNT_W];
    end

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr_arbiter (
        .req_i   (req_i),
        .ptr_i   (rr_ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    assign ptr_after = (grant_idx_q == IDX_W'(N_REQ - 1)) ? '0 : grant_idx_q + 1'b1;

`ifdef DELAY_ARBITER_ABORT_EN
    logic aborted_q, aborted_d;
    assign abort_hit = abort_i[grant_idx_q] && ((state_q == LOAD) || (state_q == RUN));
    assign aborted_d = abort_hit;
    assign aborted_o = aborted_q;
`else
    assign abort_hit = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        grant_idx_d   = grant_idx_q;
        rr_ptr_d      = rr_ptr_q;
        count_value_d = count_value_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_idx_d   = pick_idx;
                    count_value_d = delay_slice[pick_idx];
                    state_d       = LOAD;
                end
            end
            LOAD: state_d = RUN;
            RUN: begin
                if (!timer_delay_pending_i) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                rr_ptr_d = ptr_after;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort_hit) begin
            state_d = DONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_idx_q   <= '0;
            rr_ptr_q      <= '0;
            count_value_q <= '0;
`ifdef DELAY_ARBITER_ABORT_EN
            aborted_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            grant_idx_q   <= grant_idx_d;
            rr_ptr_q      <= rr_ptr_d;
            count_value_q <= count_value_d;
`ifdef DELAY_ARBITER_ABORT_EN
            aborted_q     <= aborted_d;
`endif
        end
    end

    // Outputs decode straight from state so an async reset clears them at once.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_done
        assign done_o[gi] = (state_q == DONE) && (grant_idx_q == IDX_W'(gi));
    end

    assign busy_o                   = (state_q != IDLE);
    assign grant_idx_o              = grant_idx_q;
    assign timer_rst_o              = (state_q == LOAD);
    assign timer_enable_o           = (state_q == RUN);
    assign timer_mode_o             = TIMER_MODE_COUNT_DOWN;
    assign timer_count_down_value_o = count_value_q;

endmodule
